// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-path definitions: data width, canonical NOP,
// responder FSM states and the word-address legality check.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_t;

    // True when a byte address is not word aligned or falls past the last stored word.
    function automatic logic addr_bad(
        input logic [XLEN-1:0] addr,
        input int unsigned     depth_words
    );
        logic [XLEN-1:0] word_idx;
        word_idx = {2'b00, addr[XLEN-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port and one asynchronous
// read port that the responder samples on the edge it enters RESP.
module imem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_idx,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem_r [DEPTH_WORDS];

    // Program-load write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Reading the pre-edge contents gives read-before-write on a same-edge collision.
    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/instr_mem_responder.sv
// Single-outstanding instruction fetch responder with fixed response latency,
// misalignment/range error reporting and a program-load write port.
module instr_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_instr,
    output logic            rsp_err,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_addr,
    input  logic [XLEN-1:0] load_data
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    imem_state_t     state_r;
    logic [3:0]      cnt_r;
    logic [XLEN-1:0] addr_r;
    logic            req_ready_r;
    logic            rsp_valid_r;
    logic [XLEN-1:0] rsp_instr_r;
    logic            rsp_err_r;

    logic [XLEN-1:0] cap_addr_s;
    logic            cap_bad_s;
    logic            wr_en_s;
    logic [XLEN-1:0] rd_data_s;

    // With LATENCY=1 the capture edge is the acceptance edge, so read straight from req_addr.
    always_comb begin
        cap_addr_s = addr_r;
        if (state_r == ST_IDLE) begin
            cap_addr_s = req_addr;
        end else begin
            cap_addr_s = addr_r;
        end
        cap_bad_s = addr_bad(cap_addr_s, DEPTH_WORDS);
        wr_en_s   = load_en && !reset && !addr_bad(load_addr, DEPTH_WORDS);
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_imem_array (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_idx  (load_addr[AW+1:2]),
        .wr_data (load_data),
        .rd_idx  (cap_addr_s[AW+1:2]),
        .rd_data (rd_data_s)
    );

    // Fetch FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= {XLEN{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_instr_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r      <= req_addr;
                        req_ready_r <= 1'b0;
                        if (LATENCY == 1) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_instr_r <= cap_bad_s ? NOP_INSTR : rd_data_s;
                            rsp_err_r   <= cap_bad_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= LAT_M1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r     <= ST_RESP;
                        cnt_r       <= 4'd0;
                        rsp_valid_r <= 1'b1;
                        rsp_instr_r <= cap_bad_s ? NOP_INSTR : rd_data_s;
                        rsp_err_r   <= cap_bad_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Response is held until the requester takes it; new requests wait a cycle.
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_instr = rsp_instr_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: LATENCY=2 instance for the main scenarios, LATENCY=1
// instance for back-to-back fetches with the response always accepted.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, rsp_ready = 1'b1, load_en = 1'b0;
    logic [31:0] req_addr = 32'd0, load_addr = 32'd0, load_data = 32'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_instr;

    logic        req_valid_b = 1'b0, load_en_b = 1'b0;
    logic [31:0] req_addr_b = 32'd0, load_addr_b = 32'd0, load_data_b = 32'd0;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_instr_b;

    int          vecs = 0;
    int          errs = 0;
    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [32:0] e_a, e_b;

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    instr_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(1'b1), .rsp_instr(rsp_instr_b), .rsp_err(rsp_err_b),
        .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %08h, want %08h", name, act, want);
        end
    endtask

    // Monitor for the LATENCY=2 instance: every accepted response is popped and compared.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (q_a.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL a_unexpected_rsp: got %08h, want no response", rsp_instr);
            end else begin
                e_a = q_a.pop_front();
                chk("a_rsp_instr", rsp_instr, e_a[31:0]);
                chk("a_rsp_err", {31'd0, rsp_err}, {31'd0, e_a[32]});
            end
        end
    end

    // Monitor for the LATENCY=1 instance (response always accepted).
    always @(negedge clk) begin
        if (!reset && rsp_valid_b) begin
            if (q_b.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL b_unexpected_rsp: got %08h, want no response", rsp_instr_b);
            end else begin
                e_b = q_b.pop_front();
                chk("b_rsp_instr", rsp_instr_b, e_b[31:0]);
                chk("b_rsp_err", {31'd0, rsp_err_b}, {31'd0, e_b[32]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic load_b(input logic [31:0] a, input logic [31:0] d);
        load_en_b = 1'b1; load_addr_b = a; load_data_b = d;
        step();
        load_en_b = 1'b0;
    endtask

    task automatic fetch_a(input logic [31:0] a, input logic [31:0] want, input logic err);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        chk("a_req_ready_wait", {31'd0, req_ready}, 32'd1);
        q_a.push_back({err, want});
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin step(); n++; end
        chk("a_latency", 32'(n), 32'd2);
        n = 0;
        while (rsp_valid && n < 20) begin step(); n++; end
        chk("a_rsp_drained", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        step();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        step();
        reset = 1'b0;
        chk("rst_req_ready_release", {31'd0, req_ready}, 32'd1);
        step();
        chk("rst_req_ready_next", {31'd0, req_ready}, 32'd1);

        load_a(32'h0000_0000, 32'h0050_0093);
        load_a(32'h0000_0004, 32'hCAFE_F00D);
        load_a(32'h0000_0008, 32'h1111_1111);
        load_a(32'h0000_0FFC, 32'h0BAD_F00D);
        // Illegal loads that would alias word 0 if not dropped.
        load_a(32'h0000_1000, 32'h7777_7777);
        load_a(32'h0000_0002, 32'h6666_6666);
        fetch_a(32'h0000_0000, 32'h0050_0093, 1'b0);

        // Response held under back-pressure; concurrent request ignored.
        rsp_ready = 1'b0;
        q_a.push_back({1'b0, 32'hCAFE_F00D});
        req_valid = 1'b1; req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'h4;
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_instr", rsp_instr, 32'hCAFE_F00D);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("hold_release_ready", {31'd0, req_ready}, 32'd1);
        step(); step(); step();

        fetch_a(32'h0000_0002, 32'h0000_0013, 1'b1);
        fetch_a(32'h0000_1000, 32'h0000_0013, 1'b1);
        fetch_a(32'h0000_0FFC, 32'h0BAD_F00D, 1'b0);

        // Load on the RESP-entry edge of the same word returns the old word.
        q_a.push_back({1'b0, 32'h1111_1111});
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
        step();
        load_en = 1'b0;
        chk("coll_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        step(); step();
        fetch_a(32'h0000_0008, 32'hDEAD_BEEF, 1'b0);

        // Load on the acceptance edge (earlier than capture) returns the new word.
        q_a.push_back({1'b0, 32'h00A0_0113});
        req_valid = 1'b1; req_addr = 32'h0;
        load_en = 1'b1; load_addr = 32'h0; load_data = 32'h00A0_0113;
        step();
        req_valid = 1'b0; load_en = 1'b0;
        step(); step(); step();

        // Reset mid-WAIT: request aborted, load during reset ignored.
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        load_en = 1'b1; load_addr = 32'h4; load_data = 32'h1234_5678;
        step(); step();
        load_en = 1'b0;
        reset = 1'b0;
        chk("rstw_req_ready_release", {31'd0, req_ready}, 32'd1);
        step();
        chk("rstw_req_ready_next", {31'd0, req_ready}, 32'd1);
        step(); step(); step();
        chk("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Reset while a response is being presented clears it without a clock edge.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        step();
        chk("rstr_pre_valid", {31'd0, rsp_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstr_async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstr_async_instr", rsp_instr, 32'd0);
        step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        step(); step(); step();

        fetch_a(32'h0000_0004, 32'hCAFE_F00D, 1'b0);
        fetch_a(32'h0000_0008, 32'hDEAD_BEEF, 1'b0);
        fetch_a(32'h0000_0000, 32'h00A0_0113, 1'b0);

        // LATENCY=1 back-to-back: one response every two cycles, in order.
        load_b(32'h0, 32'h0010_0093);
        load_b(32'h4, 32'h0020_0113);
        load_b(32'h8, 32'h0030_0193);
        q_b.push_back({1'b0, 32'h0010_0093});
        q_b.push_back({1'b0, 32'h0020_0113});
        q_b.push_back({1'b0, 32'h0030_0193});
        req_valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr_b = 32'(i * 4);
            chk("b_req_ready_idle", {31'd0, req_ready_b}, 32'd1);
            step();
            chk("b_rsp_valid_lat1", {31'd0, rsp_valid_b}, 32'd1);
            chk("b_req_ready_busy", {31'd0, req_ready_b}, 32'd0);
            step();
        end
        req_valid_b = 1'b0;
        step(); step(); step();

        chk("a_queue_empty", 32'(q_a.size()), 32'd0);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, 1024, number of 32-bit instruction words stored (power of two).
REQ-002 SHALL have parameter LATENCY, 2, cycles from request acceptance to rsp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address of the instruction (the PC).
REQ-008 SHALL have port rsp_valid  output  1  response word valid.
REQ-009 SHALL have port rsp_ready  input  1  requester accepts the response this cycle.
REQ-010 SHALL have port rsp_instr  output  32  fetched instruction word.
REQ-011 SHALL have port rsp_err  output  1  request was misaligned or out of range.
REQ-012 SHALL have port load_en  input  1  program-load write strobe.
REQ-013 SHALL have port load_addr  input  32  byte address of the load write.
REQ-014 SHALL have port load_data  input  32  word written on load_en.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; at most one request outstanding.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, and req_addr is registered at that edge.
REQ-017 SHALL transition on acceptance: IDLE->RESP when LATENCY=1; otherwise IDLE->WAIT with the latency counter loaded to LATENCY-1.
REQ-018 SHALL decrement the counter each cycle in WAIT and move WAIT->RESP when it reaches 1, so that rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-019 SHALL capture rsp_instr/rsp_err on the edge entering RESP and hold them, together with rsp_valid=1, stable until rsp_ready=1.
REQ-020 SHALL, in RESP with rsp_ready=1, deassert rsp_valid and return to IDLE on that edge; the next request is accepted no earlier than the following cycle.
REQ-021 SHALL flag rsp_err=1 and return rsp_instr=32'h00000013 (NOP) when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS; otherwise rsp_err=0 and rsp_instr=mem[req_addr[31:2]].
REQ-022 SHALL write load_data to mem[load_addr[31:2]] on any edge with load_en=1, in every state; misaligned or out-of-range load writes SHALL be silently dropped.
REQ-023 SHALL give read-before-write on collision: a load write on the same edge that captures the response to the same word yields the old word; a load write on any earlier edge yields the new word.
REQ-024 SHALL ignore req_valid and req_addr in WAIT and RESP (no queuing, no error).

Reset
REQ-025 SHALL, while reset=1, force state IDLE, counter 0, rsp_valid=0, rsp_instr=0, rsp_err=0 immediately (asynchronously).
REQ-026 SHALL drive req_ready=1 in the first cycle after reset is released.
REQ-027 SHALL abort any request in WAIT or RESP on reset with no response ever delivered.
REQ-028 SHALL leave memory contents unchanged by reset and SHALL ignore load_en while reset=1.

Structure
REQ-029 SHALL take the FSM state enum, NOP_INSTR=32'h00000013, and XLEN=32 from the shared riscv_pkg package.
REQ-030 SHALL instantiate one sub-module, imem_array, holding the storage: one synchronous write port and one read port sampled on the RESP-entry edge.

Verification
REQ-031 SHALL cover load 0x00500093 at 0x0, LATENCY=2, request 0x0 -> rsp_valid exactly 2 cycles after acceptance, rsp_instr=0x00500093, rsp_err=0.
REQ-032 SHALL cover rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_instr stable, req_ready=0, a request with req_valid=1 on 0x4 ignored.
REQ-033 SHALL cover request 0x2, then 0x1000 with DEPTH_WORDS=1024 -> both rsp_err=1, rsp_instr=0x00000013.
REQ-034 SHALL cover a load of 0xDEADBEEF to 0x8 on the RESP-entry edge of a request to 0x8 holding 0x11111111 -> response 0x11111111; a repeated fetch -> 0xDEADBEEF.
REQ-035 SHALL cover reset asserted mid-WAIT -> rsp_valid=0 immediately, no response after release, req_ready=1 one cycle later, memory intact.
REQ-036 SHALL cover LATENCY=1 with back-to-back requests, rsp_ready tied 1 -> one response every 2 cycles, in order, correct data.
